// File: rtl/ps2_key_ctrl_pkg.sv
// Shared constants for the PS/2 key sequencer: FSM encoding and scan-code values.
package ps2_key_ctrl_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SC_EXT     = 8'hE0;
   localparam logic [BYTE_W-1:0] SC_BRK     = 8'hF0;
   localparam logic [BYTE_W-1:0] ASCII_NONE = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_POP     = 3'd1,
      S_DECODE  = 3'd2,
      S_LOOKUP  = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Bundle of receiver handshake, LUT port and key-status outputs of the sequencer.
interface ps2_key_ctrl_if #(
   parameter int unsigned CNT_W = 8
) ();
   import ps2_key_ctrl_pkg::*;

   logic              kbd_ready;
   logic [BYTE_W-1:0] kbd_data;
   logic              kbd_overflow;
   logic              kbd_nextdata_n;
   logic [BYTE_W-1:0] lut_addr;
   logic [BYTE_W-1:0] lut_dout;
   logic [BYTE_W-1:0] key_code;
   logic [BYTE_W-1:0] key_ascii;
   logic              key_valid;
   logic              key_ext;
   logic [CNT_W-1:0]  press_count;
   logic              evt_make;
   logic              evt_break;
   logic              ovf_sticky;

   modport master (
      input  kbd_ready, kbd_data, kbd_overflow, lut_dout,
      output kbd_nextdata_n, lut_addr, key_code, key_ascii, key_valid,
             key_ext, press_count, evt_make, evt_break, ovf_sticky
   );

   modport slave (
      output kbd_ready, kbd_data, kbd_overflow, lut_dout,
      input  kbd_nextdata_n, lut_addr, key_code, key_ascii, key_valid,
             key_ext, press_count, evt_make, evt_break, ovf_sticky
   );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Pops scan codes from the PS/2 receiver FIFO, parses E0/F0 prefixes into
// make/break events, and resolves the held key's ASCII through an external LUT.
module ps2_key_ctrl
   import ps2_key_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned COUNT_REPEAT = 0,
   parameter int unsigned LUT_LAT      = 1
) (
   input  logic           clk,
   input  logic           reset,
   ps2_key_ctrl_if.master bus
);

   localparam int unsigned LAT_W = 2;

   state_t            r_state;
   logic [BYTE_W-1:0] r_byte;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_ext_pend;
   logic              r_brk_pend;
   logic              r_nextdata_n;
   logic [BYTE_W-1:0] r_lut_addr;
   logic [BYTE_W-1:0] r_key_code;
   logic [BYTE_W-1:0] r_key_ascii;
   logic              r_key_valid;
   logic              r_key_ext;
   logic [CNT_W-1:0]  r_press_count;
   logic              r_evt_make;
   logic              r_evt_break;
   logic              r_ovf_sticky;
   logic              w_match;

   // Byte refers to the key already held, including its extended flag
   assign w_match = r_key_valid && (r_byte == r_key_code) && (r_ext_pend == r_key_ext);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_byte        <= '0;
         r_lat_cnt     <= '0;
         r_ext_pend    <= 1'b0;
         r_brk_pend    <= 1'b0;
         r_nextdata_n  <= 1'b1;
         r_lut_addr    <= '0;
         r_key_code    <= '0;
         r_key_ascii   <= ASCII_NONE;
         r_key_valid   <= 1'b0;
         r_key_ext     <= 1'b0;
         r_press_count <= '0;
         r_evt_make    <= 1'b0;
         r_evt_break   <= 1'b0;
      end else begin
         r_evt_make  <= 1'b0;
         r_evt_break <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.kbd_ready) begin
                  r_byte       <= bus.kbd_data;
                  r_nextdata_n <= 1'b0;
                  r_state      <= S_POP;
               end
            end
            S_POP: begin
               r_nextdata_n <= 1'b1;
               r_state      <= S_DECODE;
            end
            S_DECODE: begin
               r_state <= S_IDLE;
               if (r_byte == SC_EXT) begin
                  r_ext_pend <= 1'b1;
               end else if (r_byte == SC_BRK) begin
                  r_brk_pend <= 1'b1;
               end else if (r_brk_pend) begin
                  // Releases of keys other than the held one are ignored
                  if (w_match) begin
                     r_key_valid <= 1'b0;
                     r_key_ascii <= ASCII_NONE;
                     r_evt_break <= 1'b1;
                  end
                  r_ext_pend <= 1'b0;
                  r_brk_pend <= 1'b0;
               end else if (w_match) begin
                  r_ext_pend <= 1'b0;
                  if (COUNT_REPEAT != 0) begin
                     r_press_count <= r_press_count + CNT_W'(1);
                     r_evt_make    <= 1'b1;
                  end
               end else begin
                  r_key_code <= r_byte;
                  r_key_ext  <= r_ext_pend;
                  r_ext_pend <= 1'b0;
                  // Extended keys have no ASCII mapping, so skip the LUT
                  if (r_ext_pend) begin
                     r_key_ascii   <= ASCII_NONE;
                     r_key_valid   <= 1'b1;
                     r_press_count <= r_press_count + CNT_W'(1);
                     r_evt_make    <= 1'b1;
                  end else begin
                     r_lut_addr <= r_byte;
                     r_lat_cnt  <= '0;
                     r_state    <= S_LOOKUP;
                  end
               end
            end
            S_LOOKUP: begin
               if (r_lat_cnt == LAT_W'(LUT_LAT - 1)) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_lat_cnt <= r_lat_cnt + LAT_W'(1);
               end
            end
            S_CAPTURE: begin
               r_key_ascii   <= bus.lut_dout;
               r_key_valid   <= 1'b1;
               r_press_count <= r_press_count + CNT_W'(1);
               r_evt_make    <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf_sticky <= 1'b0;
      end else if (bus.kbd_overflow) begin
         r_ovf_sticky <= 1'b1;
      end
   end

   assign bus.kbd_nextdata_n = r_nextdata_n;
   assign bus.lut_addr       = r_lut_addr;
   assign bus.key_code       = r_key_code;
   assign bus.key_ascii      = r_key_ascii;
   assign bus.key_valid      = r_key_valid;
   assign bus.key_ext        = r_key_ext;
   assign bus.press_count    = r_press_count;
   assign bus.evt_make       = r_evt_make;
   assign bus.evt_break      = r_evt_break;
   assign bus.ovf_sticky     = r_ovf_sticky;

endmodule
